// File: rtl/sprite_mixer.sv
// Two-stage sprite mixer: per-pixel priority select across layers, then palette lookup.
// Optional build macro SPRITE_COLL_EN adds sticky per-layer collision flags.
module sprite_mixer #(
  parameter int LAYERS    = 4,
  parameter int SPR_DATAW = 4,
  parameter int COLRW     = 4,
  parameter int TRANS_IDX = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame,
  input  logic                          de_in,
  input  logic [LAYERS*SPR_DATAW-1:0]   pix_in,
  input  logic [LAYERS-1:0]             drawing_in,
  input  logic [SPR_DATAW-1:0]          bg_idx,
  input  logic                          pal_we,
  input  logic [SPR_DATAW-1:0]          pal_addr,
  input  logic [3*COLRW-1:0]            pal_data,
  output logic [3*COLRW-1:0]            rgb_out,
  output logic                          de_out,
  output logic [$clog2(LAYERS):0]       hit_layer
`ifdef SPRITE_COLL_EN
  ,
  input  logic                          coll_clr,
  output logic [LAYERS-1:0]             collision
`endif
);

  localparam int HITW = $clog2(LAYERS) + 1;
  localparam int NPAL = 2 ** SPR_DATAW;
  localparam int RGBW = 3 * COLRW;

  logic [LAYERS-1:0]    opaque;
  logic [SPR_DATAW-1:0] s1_idx_d, s1_idx_q;
  logic [HITW-1:0]      s1_hit_d, s1_hit_q;
  logic                 s1_de_d, s1_de_q;
  logic [RGBW-1:0]      rgb_d, rgb_q;
  logic                 de_d, de_q;
  logic [HITW-1:0]      hit_d, hit_q;
  logic [RGBW-1:0]      pal_d [NPAL];
  logic [RGBW-1:0]      pal_q [NPAL];

  always_comb begin
    for (int k = 0; k < LAYERS; k++) begin
      opaque[k] = drawing_in[k] &&
                  (pix_in[k*SPR_DATAW +: SPR_DATAW] != SPR_DATAW'(TRANS_IDX));
    end
  end

  // NOTE: every variable gets a default before any conditional assignment,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    s1_idx_d = bg_idx;
    s1_hit_d = HITW'(LAYERS);
    s1_de_d  = de_in;
    // Scan from the highest layer down so the lowest-numbered opaque layer wins.
    for (int k = LAYERS - 1; k >= 0; k--) begin
      if (opaque[k]) begin
        s1_idx_d = pix_in[k*SPR_DATAW +: SPR_DATAW];
        s1_hit_d = HITW'(k);
      end
    end
  end

  // Blank pixels output black and report the background layer.
  always_comb begin
    de_d  = s1_de_q;
    rgb_d = s1_de_q ? pal_q[s1_idx_q] : '0;
    hit_d = s1_de_q ? s1_hit_q : HITW'(LAYERS);
  end

  always_comb begin
    for (int i = 0; i < NPAL; i++) begin
      pal_d[i] = pal_q[i];
    end
    if (pal_we) begin
      pal_d[pal_addr] = pal_data;
    end
  end

  // NOTE: non-blocking assignments make every register sample the pre-edge
  // values, which is what gives the palette its read-old-on-write behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_idx_q <= '0;
      s1_hit_q <= HITW'(LAYERS);
      s1_de_q  <= 1'b0;
      rgb_q    <= '0;
      de_q     <= 1'b0;
      hit_q    <= HITW'(LAYERS);
    end else begin
      s1_idx_q <= s1_idx_d;
      s1_hit_q <= s1_hit_d;
      s1_de_q  <= s1_de_d;
      rgb_q    <= rgb_d;
      de_q     <= de_d;
      hit_q    <= hit_d;
    end
  end

  // NOTE: the palette is built from flops with a reset because it must read
  // back as zero after reset; a RAM macro could not be cleared this way.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NPAL; i++) begin
        pal_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NPAL; i++) begin
        pal_q[i] <= pal_d[i];
      end
    end
  end

  assign rgb_out   = rgb_q;
  assign de_out    = de_q;
  assign hit_layer = hit_q;

`ifdef SPRITE_COLL_EN
  logic [LAYERS-1:0] coll_d, coll_q;
  logic              multi_hit;

  // Two or more opaque bits set: clearing the lowest leaves something behind.
  assign multi_hit = de_in && ((opaque & (opaque - 1'b1)) != '0);

  always_comb begin
    coll_d = (frame || coll_clr) ? '0 : coll_q;
    if (multi_hit) begin
      coll_d = coll_d | opaque;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coll_q <= '0;
    end else begin
      coll_q <= coll_d;
    end
  end

  assign collision = coll_q;
`else
  logic unused_frame;
  assign unused_frame = frame;
`endif

endmodule

// File: tb/tb_sprite_mixer.sv
// Directed self-checking bench for sprite_mixer (default parameters).
module tb_sprite_mixer;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame;
  logic        de_in;
  logic [15:0] pix_in;
  logic [3:0]  drawing_in;
  logic [3:0]  bg_idx;
  logic        pal_we;
  logic [3:0]  pal_addr;
  logic [11:0] pal_data;
  logic [11:0] rgb_out;
  logic        de_out;
  logic [2:0]  hit_layer;
`ifdef SPRITE_COLL_EN
  logic        coll_clr;
  logic [3:0]  collision;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  sprite_mixer dut (
    .clk        (clk),
    .rst        (rst),
    .frame      (frame),
    .de_in      (de_in),
    .pix_in     (pix_in),
    .drawing_in (drawing_in),
    .bg_idx     (bg_idx),
    .pal_we     (pal_we),
    .pal_addr   (pal_addr),
    .pal_data   (pal_data),
    .rgb_out    (rgb_out),
    .de_out     (de_out),
    .hit_layer  (hit_layer)
`ifdef SPRITE_COLL_EN
    ,
    .coll_clr   (coll_clr),
    .collision  (collision)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pal_write(input logic [3:0] a, input logic [11:0] d);
    pal_we   = 1'b1;
    pal_addr = a;
    pal_data = d;
    step();
    pal_we   = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    frame      = 1'b0;
    de_in      = 1'b0;
    pix_in     = '0;
    drawing_in = '0;
    bg_idx     = '0;
    pal_we     = 1'b0;
    pal_addr   = '0;
    pal_data   = '0;
`ifdef SPRITE_COLL_EN
    coll_clr   = 1'b0;
`endif
    #3;
    check("rst_rgb", 32'(rgb_out), 32'h000);
    check("rst_de", 32'(de_out), 32'd0);
    check("rst_hit", 32'(hit_layer), 32'd4);
    step();
    rst = 1'b0;
    step();

    pal_write(4'd3, 12'hF00);
    pal_write(4'd0, 12'h00F);
    pal_write(4'd5, 12'h0A0);

    // Background only
    de_in = 1'b1;
    step();
    check("lat1_rgb", 32'(rgb_out), 32'h000);
    check("lat1_de", 32'(de_out), 32'd0);
    step();
    check("bg_rgb", 32'(rgb_out), 32'h00F);
    check("bg_hit", 32'(hit_layer), 32'd4);
    check("bg_de", 32'(de_out), 32'd1);

    // Layer 1 transparent, layer 2 opaque
    pix_in     = {4'd0, 4'd3, 4'd0, 4'd0};
    drawing_in = 4'b0110;
    step(); step();
    check("l2_rgb", 32'(rgb_out), 32'hF00);
    check("l2_hit", 32'(hit_layer), 32'd2);

    // Layers 0 and 2 opaque: layer 0 wins
    pix_in     = {4'd0, 4'd3, 4'd0, 4'd5};
    drawing_in = 4'b0101;
    step(); step();
    check("prio_rgb", 32'(rgb_out), 32'h0A0);
    check("prio_hit", 32'(hit_layer), 32'd0);
`ifdef SPRITE_COLL_EN
    check("coll_set", 32'(collision), 32'h5);
`endif

    // Layer 3 only, then a non-zero background index
    pix_in     = {4'd3, 4'd0, 4'd0, 4'd0};
    drawing_in = 4'b1000;
    step(); step();
    check("l3_hit", 32'(hit_layer), 32'd3);
    check("l3_rgb", 32'(rgb_out), 32'hF00);
    drawing_in = 4'b0000;
    bg_idx     = 4'd5;
    step(); step();
    check("bg5_rgb", 32'(rgb_out), 32'h0A0);
    check("bg5_hit", 32'(hit_layer), 32'd4);
`ifdef SPRITE_COLL_EN
    check("coll_sticky", 32'(collision), 32'h5);
    frame = 1'b1;
    step();
    frame = 1'b0;
    check("coll_frame_clr", 32'(collision), 32'h0);
`endif

    // Palette write while index 3 sits in stage 1
    pix_in     = {4'd0, 4'd3, 4'd0, 4'd0};
    drawing_in = 4'b0100;
    step();
    pal_we   = 1'b1;
    pal_addr = 4'd3;
    pal_data = 12'h0FF;
    step();
    pal_we   = 1'b0;
    check("wr_old_rgb", 32'(rgb_out), 32'hF00);
    step();
    check("wr_new_rgb", 32'(rgb_out), 32'h0FF);

    // Blanked pixel with two opaque layers
    de_in      = 1'b0;
    pix_in     = {4'd0, 4'd3, 4'd0, 4'd5};
    drawing_in = 4'b0101;
    step(); step();
    check("blank_rgb", 32'(rgb_out), 32'h000);
    check("blank_de", 32'(de_out), 32'd0);
    check("blank_hit", 32'(hit_layer), 32'd4);
`ifdef SPRITE_COLL_EN
    check("blank_coll", 32'(collision), 32'h0);
`endif

    // Mid-line reset
    de_in      = 1'b1;
    pix_in     = {4'd0, 4'd3, 4'd0, 4'd0};
    drawing_in = 4'b0100;
    step(); step();
    check("pre_rst_rgb", 32'(rgb_out), 32'h0FF);
    #2;
    rst = 1'b1;
    #1;
    check("async_rgb", 32'(rgb_out), 32'h000);
    check("async_de", 32'(de_out), 32'd0);
    check("async_hit", 32'(hit_layer), 32'd4);
    step();
    rst = 1'b0;
    step();
    check("post_rst_flush_de", 32'(de_out), 32'd0);
    step();
    check("post_rst_de", 32'(de_out), 32'd1);
    check("post_rst_hit", 32'(hit_layer), 32'd2);
    check("post_rst_pal", 32'(rgb_out), 32'h000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
